// File: rtl/baud_pkg.sv
// Shared constants for the baud tick generator.
//   FRAC_W_DEF / CNT_W_DEF : default divider widths
//   BAUD_*                 : (integer, fractional) divisor pairs for 16x
//                            oversampling from a 50 MHz clock
package baud_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;

  typedef struct packed {
    logic [CNT_W_DEF-1:0]  div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
  } baud_div_t;

  // Period = N + 1 + F/16 cycles of 20 ns; 16 periods per bit.
  localparam baud_div_t BAUD_9600   = '{div_int: 16'd324, div_frac: 4'd8};
  localparam baud_div_t BAUD_19200  = '{div_int: 16'd161, div_frac: 4'd12};
  localparam baud_div_t BAUD_115200 = '{div_int: 16'd26,  div_frac: 4'd2};

endpackage

// File: rtl/frac_accum.sv
// Fractional phase accumulator. On each enabled cycle adds addend_i to acc
// (wrapping at FRAC_W bits) and registers the carry-out, which stretches the
// following period by one cycle.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear (priority over en_i)
//   en_i          : add strobe
//   addend_i      : fractional divisor
//   acc_o/carry_o : accumulator value and last carry-out
module frac_accum
  import baud_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [FRAC_W-1:0] addend_i,
  output logic [FRAC_W-1:0] acc_o,
  output logic              carry_o
);

  logic [FRAC_W-1:0] acc_q;
  logic              carry_q;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, addend_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (clr_i) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (en_i) begin
      {carry_q, acc_q} <= sum;
    end
  end

  assign acc_o   = acc_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable fractional baud tick generator.
//   clk_i, rst_ni      : clock, async active-low reset
//   en_i               : count enable (low freezes state, no ticks)
//   restart_i          : synchronous phase restart (priority over en_i)
//   div_int_i/div_frac_i/div_load_i : divisor request and capture strobe
//   ovs_tick_o         : oversample tick, average period N+1+F/2^FRAC_W
//   bit_tick_o         : every OVS-th ovs_tick (end of slot OVS-1)
//   ovs_phase_o        : current oversample slot within the bit
//   load_pending_o     : shadow divisor waiting for a period boundary
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FRAC_W       = FRAC_W_DEF,
  parameter int OVS          = 16,
  parameter int DEFAULT_INT  = 163,
  parameter int DEFAULT_FRAC = 0,
  localparam int PH_W        = $clog2(OVS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              restart_i,
  input  logic [CNT_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic              div_load_i,
  output logic              ovs_tick_o,
  output logic              bit_tick_o,
  output logic [PH_W-1:0]   ovs_phase_o,
  output logic              load_pending_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d, act_int_q, act_int_d, sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              pend_q, pend_d, ovs_q, ovs_d, bit_q, bit_d;
  logic              carry, wrap, phase_last;
  logic [CNT_W:0]    lim;
  logic [FRAC_W-1:0] acc_unused;

  frac_accum #(.FRAC_W(FRAC_W)) u_acc (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (restart_i),
    .en_i     (en_i & wrap),
    .addend_i (act_frac_q),
    .acc_o    (acc_unused),
    .carry_o  (carry)
  );

  // ">=" rather than "==" so a divisor lowered below cnt wraps at once.
  assign lim        = {1'b0, act_int_q} + {{CNT_W{1'b0}}, carry};
  assign wrap       = ({1'b0, cnt_q} >= lim);
  assign phase_last = (phase_q == PH_W'(OVS - 1));

  always_comb begin
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    ovs_d      = 1'b0;
    bit_d      = 1'b0;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    if (restart_i) begin
      cnt_d   = '0;
      phase_d = '0;
      if (div_load_i) begin
        act_int_d  = div_int_i;
        act_frac_d = div_frac_i;
        pend_d     = 1'b0;
      end else if (pend_q) begin
        act_int_d  = sh_int_q;
        act_frac_d = sh_frac_q;
        pend_d     = 1'b0;
      end
    end else begin
      if (en_i) begin
        if (wrap) begin
          cnt_d   = '0;
          ovs_d   = 1'b1;
          bit_d   = phase_last;
          phase_d = phase_last ? '0 : phase_q + PH_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A fresh load overrides any application this edge; the new shadow
      // waits for the next period boundary (or idle edge).
      if (div_load_i) begin
        sh_int_d  = div_int_i;
        sh_frac_d = div_frac_i;
        pend_d    = 1'b1;
      end else if (pend_q && (!en_i || wrap)) begin
        act_int_d  = sh_int_q;
        act_frac_d = sh_frac_q;
        pend_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      phase_q    <= '0;
      ovs_q      <= 1'b0;
      bit_q      <= 1'b0;
      act_int_q  <= CNT_W'(DEFAULT_INT);
      act_frac_q <= FRAC_W'(DEFAULT_FRAC);
      sh_int_q   <= CNT_W'(DEFAULT_INT);
      sh_frac_q  <= FRAC_W'(DEFAULT_FRAC);
      pend_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      ovs_q      <= ovs_d;
      bit_q      <= bit_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
    end
  end

  assign ovs_tick_o     = ovs_q;
  assign bit_tick_o     = bit_q;
  assign ovs_phase_o    = phase_q;
  assign load_pending_o = pend_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
module tb_baud_tick_gen;

  localparam int OVS = 16;
  localparam int FSCALE = 16; // 2^FRAC_W

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, restart, div_load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        ovs_tick, bit_tick, load_pending;
  logic [3:0]  ovs_phase;

  int n_assert = 0;
  int n_fail   = 0;

  baud_tick_gen dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .en_i           (en),
    .restart_i      (restart),
    .div_int_i      (div_int),
    .div_frac_i     (div_frac),
    .div_load_i     (div_load),
    .ovs_tick_o     (ovs_tick),
    .bit_tick_o     (bit_tick),
    .ovs_phase_o    (ovs_phase),
    .load_pending_o (load_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic e, input logic r, input logic ld,
                     input logic [15:0] di, input logic [3:0] df);
    en = e; restart = r; div_load = ld; div_int = di; div_frac = df;
    @(posedge clk);
    #1;
  endtask

  // From a fresh phase (cnt=acc=carry=phase=0) with divisor (n,f), the k-th
  // tick lands on enabled edge k*(n+1) + floor((k-1)*f/16). Disabled cycles
  // advance nothing. Optional random enable and a forced idle gap.
  task automatic run_check(input int n, input int f, input int ncyc,
                           input bit rnd, input int gs, input int gl);
    int  e = 0;
    int  k = 1;
    int  next_t = n + 1;
    int  ph = 0;
    logic ev, exp_t, exp_b;
    for (int i = 0; i < ncyc; i++) begin
      if (i >= gs && i < gs + gl) ev = 1'b0;
      else if (rnd)               ev = ($urandom_range(3) != 0);
      else                        ev = 1'b1;
      cyc(ev, 1'b0, 1'b0, 16'd0, 4'd0);
      exp_t = 1'b0;
      exp_b = 1'b0;
      if (ev) begin
        e++;
        if (e == next_t) begin
          exp_t = 1'b1;
          ph = (ph + 1) % OVS;
          exp_b = (ph == 0);
          k++;
          next_t = k * (n + 1) + ((k - 1) * f) / FSCALE;
        end
      end
      chk("ovs_tick", {31'd0, ovs_tick}, {31'd0, exp_t});
      chk("bit_tick", {31'd0, bit_tick}, {31'd0, exp_b});
      chk("ovs_phase", {28'd0, ovs_phase}, ph);
    end
  endtask

  initial begin
    int n, f;
    logic exp_t;
    rst_n = 1'b0;
    en = 1'b0; restart = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovs_tick", {31'd0, ovs_tick}, 0);
    chk("rst_bit_tick", {31'd0, bit_tick}, 0);
    chk("rst_phase", {28'd0, ovs_phase}, 0);
    chk("rst_pending", {31'd0, load_pending}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Defaults: 164-cycle ticks, bit tick every 2624 cycles.
    run_check(163, 0, 2624 + 200, 1'b0, -1, 0);

    // 9600 baud divisor loaded together with a restart.
    cyc(1'b1, 1'b1, 1'b1, 16'd324, 4'd8);
    chk("rl_ovs_tick", {31'd0, ovs_tick}, 0);
    chk("rl_pending", {31'd0, load_pending}, 0);
    run_check(324, 8, 5208 + 400, 1'b0, -1, 0);

    // Random divisors with random enable gaps.
    repeat (6) begin
      n = $urandom_range(0, 20);
      f = $urandom_range(0, 15);
      cyc(1'b1, 1'b1, 1'b1, 16'(n), 4'(f));
      run_check(n, f, 300, 1'b1, -1, 0);
    end

    // Divisor (0,0): a tick on every enabled cycle.
    cyc(1'b1, 1'b1, 1'b1, 16'd0, 4'd0);
    run_check(0, 0, 40, 1'b0, -1, 0);

    // Restart at cnt=80, phase=5: no tick, next tick 164 cycles later, phase 1.
    cyc(1'b1, 1'b1, 1'b1, 16'd163, 4'd0);
    run_check(163, 0, 5 * 164 + 80, 1'b0, -1, 0);
    cyc(1'b1, 1'b1, 1'b0, 16'd0, 4'd0);
    chk("rs_ovs_tick", {31'd0, ovs_tick}, 0);
    chk("rs_bit_tick", {31'd0, bit_tick}, 0);
    chk("rs_phase", {28'd0, ovs_phase}, 0);
    run_check(163, 0, 170, 1'b0, -1, 0);

    // Mid-period load of (10,0): current period still 164, then 11.
    cyc(1'b1, 1'b1, 1'b0, 16'd0, 4'd0);
    for (int e = 1; e <= 200; e++) begin
      cyc(1'b1, 1'b0, e == 51, 16'd10, 4'd0);
      exp_t = (e == 164) || (e > 164 && ((e - 164) % 11) == 0);
      chk("ml_ovs_tick", {31'd0, ovs_tick}, {31'd0, exp_t});
      chk("ml_pending", {31'd0, load_pending}, (e >= 51 && e < 164) ? 1 : 0);
    end

    // 50-cycle enable gap: the interrupted period ends 50 cycles late.
    cyc(1'b1, 1'b1, 1'b1, 16'd163, 4'd0);
    run_check(163, 0, 400, 1'b0, 100, 50);

    // Idle-time load below the current count: applied while idle, wraps at once.
    cyc(1'b1, 1'b1, 1'b0, 16'd0, 4'd0);
    run_check(163, 0, 100, 1'b0, -1, 0);
    cyc(1'b0, 1'b0, 1'b1, 16'd5, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    chk("idle_pending", {31'd0, load_pending}, 0);
    chk("idle_ovs_tick", {31'd0, ovs_tick}, 0);
    cyc(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    chk("ge_wrap_tick", {31'd0, ovs_tick}, 1);
    for (int e = 1; e <= 12; e++) begin
      cyc(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
      chk("short_period", {31'd0, ovs_tick}, (e % 6 == 0) ? 1 : 0);
    end

    // Async reset mid-period with a load pending.
    cyc(1'b1, 1'b1, 1'b1, 16'd163, 4'd0);
    run_check(163, 0, 40, 1'b0, -1, 0);
    cyc(1'b1, 1'b0, 1'b1, 16'd7, 4'd3);
    chk("pre_rst_pending", {31'd0, load_pending}, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pending", {31'd0, load_pending}, 0);
    chk("arst_ovs_tick", {31'd0, ovs_tick}, 0);
    chk("arst_bit_tick", {31'd0, bit_tick}, 0);
    chk("arst_phase", {28'd0, ovs_phase}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_check(163, 0, 400, 1'b0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Programmable baud-rate tick generator for the pulser UART path. It replaces the fixed 16-bit max-count tick counter with a parametrised divider that adds:
- a fractional divisor, for accurate standard rates from a 50 MHz clock;
- an oversampling tick and a derived bit tick;
- a glitch-free divisor reload;
- a synchronous phase restart.

It feeds the UART receiver (oversample tick) and transmitter (bit tick).

## Interface
- CNT_W, 16, width of integer divisor and period counter
- FRAC_W, 4, width of fractional divisor / accumulator
- OVS, 16, oversample ticks per bit tick (≥2)
- DEFAULT_INT, 163, active integer divisor after reset
- DEFAULT_FRAC, 0, active fractional divisor after reset
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- en  in  1  count enable; low freezes all state, no ticks
- restart  in  1  synchronous phase restart pulse
- div_int  in  CNT_W  requested integer divisor N (period N+1 cycles)
- div_frac  in  FRAC_W  requested fractional divisor F (units of 2^-FRAC_W cycles)
- div_load  in  1  single-cycle strobe capturing div_int/div_frac into shadow
- ovs_tick  out  1  one-cycle oversample pulse, registered
- bit_tick  out  1  one-cycle pulse on every OVS-th ovs_tick, registered
- ovs_phase  out  clog2(OVS)  index of current oversample slot within bit
- load_pending  out  1  shadow divisor waiting to be applied

## Operation
- Active divisor pair (act_int, act_frac); shadow pair plus pending flag.
- Period counter cnt increments each en cycle. At the edge where cnt == act_int + carry:
  - cnt ← 0;
  - ovs_tick ← 1;
  - acc ← acc + act_frac (FRAC_W bits, wrap);
  - carry for the next period ← carry-out of that sum.
- Otherwise ovs_tick ← 0.
- Average period = N + 1 + F/2^FRAC_W cycles. N=0, F=0 → ovs_tick every enabled cycle.
- ovs_phase increments on each ovs_tick, wrapping OVS−1 → 0. bit_tick ← 1 on the same edge that ovs_phase wraps to 0.
- div_load: shadow ← inputs, load_pending ← 1.
  - Applied (act ← shadow, pending ← 0) at the next wrap edge, so no truncated or stretched period.
  - If en=0, applied on the next clock edge.
  - A second div_load before application overwrites the shadow.
- restart (priority over en): cnt, acc, carry, ovs_phase ← 0; ticks ← 0. A pending shadow is applied immediately. div_load in the same cycle as restart is applied immediately.
- en=0: cnt, acc, ovs_phase held; ovs_tick/bit_tick ← 0 next edge.
- If act_int is lowered below current cnt, the wrap test uses ≥, so the next edge wraps. This can only occur via restart-free en=0 application.

## Timing
- Reset values: cnt=0, acc=0, carry=0, ovs_phase=0, ovs_tick=0, bit_tick=0, load_pending=0, act_int=DEFAULT_INT, act_frac=DEFAULT_FRAC.
- First ovs_tick after reset release with en=1 and divisor N: high in the cycle following the (N+1)-th enabled edge.
- Tick latency: one cycle (registered). bit_tick coincides exactly with the ovs_tick that ends slot OVS−1.
- Reset mid-period: immediate asynchronous clear. Release must be synchronised externally to clk.

## Structure
- Shared package baud_pkg:
  - FRAC_W default;
  - 50 MHz/16× constants: 9600 → (324, 8); 19200 → (161, 12); 115200 → (26, 2).
- One natural sub-module, frac_accum: FRAC_W adder holding acc and carry, with enable and clear.
- Everything else lives in baud_tick_gen.

## Test plan
- Reset defaults, en=1, no load → ovs_tick every 164 cycles; bit_tick every 2624 cycles; ovs_phase cycles 0..15.
- div_load (324, 8) → over 16 ovs periods: eight of 325 cycles and eight of 326 cycles, interleaved, total 5208 cycles.
- div_load (10, 0) mid-period of a 164-cycle period → current period completes at 164 cycles; load_pending drops at that wrap; the next period is 11 cycles.
- restart while cnt=80, ovs_phase=5 → no tick; next ovs_tick exactly 164 enabled cycles later with ovs_phase=1; restart+div_load(0, 0) together → ovs_tick every cycle.
- en low for 50 cycles mid-period → no ticks; the interrupted period resumes and ends 50 cycles late.
- Assert reset (0) mid-period with load pending → all outputs 0 and act divisor back to 163 asynchronously.
